// File: rtl/fifo_rd_stream.sv
// Turns a registered-read FIFO (data one cycle after rd_en) into a valid/ready
// stream through a 2-entry skid buffer. Optional counters under RD_STREAM_STATS_EN.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  rd_err,
    output logic [1:0]            dbg_state
`ifdef RD_STREAM_STATS_EN
    ,
    output logic [15:0]           beat_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int PTR_W = $clog2(SKID_DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_pend;
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [FIFO_WIDTH-1:0]   r_entry [SKID_DEPTH];
    logic                    r_err;
    logic                    w_pop;
    logic                    w_cap;
    logic [2:0]              w_level;

    // Stream handshake: a beat transfers on a rising edge where m_valid && m_ready;
    // while m_valid is high and m_ready low, m_data and m_valid hold unchanged.
    assign m_valid   = (r_state != S_EMPTY);
    assign m_data    = r_entry[r_head];
    assign w_pop     = m_valid && m_ready;
    assign w_cap     = r_pend && !underflow;
    assign rd_err    = r_err;
    assign dbg_state = r_state;

    // Level counts the in-flight word too, so a read is only issued when a slot
    // is guaranteed to be free by the time its data arrives.
    assign w_level = {1'b0, r_state} + {2'b00, r_pend} - {2'b00, w_pop};
    assign rd_en   = rst_n && enable && !empty && (w_level < 3'(SKID_DEPTH));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_cap) w_state_next = S_ONE;
            S_ONE: begin
                if (w_cap && !w_pop)      w_state_next = S_FULL;
                else if (!w_cap && w_pop) w_state_next = S_EMPTY;
            end
            S_FULL:  if (w_pop && !w_cap) w_state_next = S_ONE;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_pend  <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) r_entry[i] <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= rd_en;
            if (w_cap) begin
                r_entry[r_tail] <= data_out;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) r_head <= r_head + PTR_W'(1);
            // An underflowed read returns garbage: drop it and latch the error.
            if (r_pend && underflow) r_err <= 1'b1;
        end
    end

`ifdef RD_STREAM_STATS_EN
    logic [15:0] r_beat_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop)               r_beat_cnt  <= r_beat_cnt + 16'd1;
            if (m_valid && !m_ready) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign beat_cnt  = r_beat_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT and a
// scoreboard of expected words is checked on every stream beat.
module tb_fifo_rd_stream;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        empty;
    logic        underflow;
    logic [15:0] data_out;
    logic        rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        rd_err;
    logic [1:0]  dbg_state;
`ifdef RD_STREAM_STATS_EN
    logic [15:0] beat_cnt;
    logic [15:0] stall_cnt;
`endif

    fifo_rd_stream #(.FIFO_WIDTH(16), .SKID_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .empty     (empty),
        .underflow (underflow),
        .data_out  (data_out),
        .rd_en     (rd_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .rd_err    (rd_err),
        .dbg_state (dbg_state)
`ifdef RD_STREAM_STATS_EN
        ,
        .beat_cnt  (beat_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    bit          force_uf = 0;
    int          cyc = 0;
    int          rd_seen = 0;
    int          pop_cnt = 0;
    int          first_rd = -1;
    int          first_pop = -1;
    int          last_pop = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load(input logic [15:0] w, input bit expect_it);
        fifo_q.push_back(w);
        if (expect_it) exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic clear_stats();
        rd_seen = 0; pop_cnt = 0; first_rd = -1; first_pop = -1; last_pop = -1;
    endtask

    // One clock: sample just after the falling edge, model the FIFO just after the rising edge.
    task automatic tick();
        logic        got_rd;
        logic        popped;
        logic [15:0] e;
        #1;
        got_rd = rd_en;
        popped = m_valid && m_ready;
        if (got_rd) begin
            rd_seen++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (popped) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (exp_q.size() == 0) check("unexpected_word", {16'h0, m_data}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                check("word", m_data, e);
            end
        end
        @(posedge clk);
        #1;
        underflow = 1'b0;
        if (got_rd) begin
            if (fifo_q.size() == 0) check("read_when_empty", 1, 0);
            else data_out = fifo_q.pop_front();
            underflow = force_uf;
            force_uf  = 0;
        end
        empty = (fifo_q.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_err", rd_err, 0);
        check("rst_state", dbg_state, 0);
        check("rst_data", m_data, 0);
        // buffered and in-flight words are lost; whatever is still in the FIFO comes next
        exp_q.delete();
        foreach (fifo_q[i]) exp_q.push_back(fifo_q[i]);
        underflow = 1'b0;
        force_uf  = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_rd_after_rst", rd_en, (enable && fifo_q.size() != 0));
    endtask

    initial begin
        logic [15:0] w0;
        int          loaded;
        rst_n = 1'b0; enable = 1'b0; empty = 1'b1; underflow = 1'b0;
        data_out = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("init_valid", m_valid, 0);
        check("init_rd_en", rd_en, 0);
        check("init_err", rd_err, 0);
        check("init_data", m_data, 0);
        rst_n = 1'b1;

        // preloaded 1..8, full-rate streaming
        for (int i = 1; i <= 8; i++) load(16'(i), 1);
        enable = 1'b1; m_ready = 1'b1;
        clear_stats();
        drain(30);
        repeat (2) tick();
        check("burst_latency", first_pop - first_rd, 2);
        check("burst_count", pop_cnt, 8);
        check("burst_back_to_back", last_pop - first_pop, 7);
        check("burst_reads", rd_seen, 8);

        // sink stalled with 4 words queued
        m_ready = 1'b0;
        clear_stats();
        w0 = 16'($urandom_range(16'h100, 16'hFFFF));
        load(w0, 1);
        for (int i = 0; i < 3; i++) load(16'($urandom_range(0, 16'hFFFF)), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 1) begin
                check("stall_valid", m_valid, 1);
                check("stall_hold", m_data, w0);
            end
        end
        check("stall_reads", rd_seen, 2);
        check("stall_full", dbg_state, 2);
        check("stall_rd_en", rd_en, 0);
        m_ready = 1'b1;
        drain(20);
        repeat (2) tick();
        check("stall_empty_after", dbg_state, 0);

        // FIFO empty throughout
        for (int i = 0; i < 6; i++) begin
            tick();
            check("idle_rd_en", rd_en, 0);
            check("idle_valid", m_valid, 0);
        end

        // underflow on the in-flight read
        force_uf = 1;
        load(16'hDEAD, 0);
        tick();
        check("uf_err_not_yet", rd_err, 0);
        tick();
        check("uf_err_set", rd_err, 1);
        check("uf_no_word", m_valid, 0);
        repeat (3) tick();
        check("uf_still_no_word", m_valid, 0);
        load(16'h1234, 1);
        drain(10);
        check("uf_err_sticky", rd_err, 1);
        reset_pulse();
        check("uf_err_cleared", rd_err, 0);

        // reset while the buffer is full
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(16'($urandom_range(0, 16'hFFFF)), 1);
        for (int i = 0; i < 10 && dbg_state != 2'd2; i++) tick();
        check("pre_rst_full", dbg_state, 2);
        reset_pulse();
        m_ready = 1'b1;
        drain(20);
        repeat (2) tick();

`ifdef RD_STREAM_STATS_EN
        reset_pulse();
        check("stats_rst_beat", beat_cnt, 0);
        m_ready = 1'b0;
        load(16'h00AA, 1);
        repeat (4) tick();
        check("stats_stall", stall_cnt, 2);
        m_ready = 1'b1;
        drain(10);
        reset_pulse();
        loaded = 0;
        for (int i = 0; i < 72000 && (loaded < 70000 || exp_q.size() != 0); i++) begin
            if (fifo_q.size() < 3 && loaded < 70000) begin
                load(16'($urandom_range(0, 16'hFFFF)), 1);
                loaded++;
            end
            tick();
        end
        repeat (2) tick();
        check("stats_drained", exp_q.size(), 0);
        check("stats_beat_wrap", beat_cnt, 16'd4464);
        check("stats_no_stall", stall_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
